// File: rtl/filter_buffer.sv
// Filter buffer: loads a filter tile into Tout parallel banks (bank fastest,
// address slowest) and serves PE reads with a fixed 1-cycle latency.
module filter_buffer #(
  parameter int FILTER_DW        = 72,
  parameter int FILTER_BUFFER_AW = 8,
  parameter int Tout             = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load_start,
  input  logic [FILTER_BUFFER_AW:0]   i_load_words,
  input  logic                        i_wr_vld,
  input  logic [FILTER_DW-1:0]        i_wr_data,
  output logic                        o_wr_rdy,
  output logic                        o_load_done,
  input  logic                        i_release,
  output logic                        o_fb_req_possible,
  input  logic                        i_fb_req,
  input  logic [FILTER_BUFFER_AW-1:0] i_fb_addr,
  output logic [FILTER_DW-1:0]        o_fb_data0,
  output logic [FILTER_DW-1:0]        o_fb_data1,
  output logic [FILTER_DW-1:0]        o_fb_data2,
  output logic [FILTER_DW-1:0]        o_fb_data3,
  output logic                        o_fb_addr_err,
  output logic [1:0]                  fsm_state
);

  localparam int AW    = FILTER_BUFFER_AW;
  localparam int DEPTH = 2 ** AW;
  localparam int BW    = (Tout > 1) ? $clog2(Tout) : 1;
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] LAST_BANK = BW'(Tout - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t               state;
  logic [AW:0]          words_q;
  logic [AW:0]          wr_addr;
  logic [AW:0]          words_clamped;
  logic [BW-1:0]        bank;
  logic [FILTER_DW-1:0] mem     [Tout][DEPTH];
  logic [FILTER_DW-1:0] rd_data [Tout];
  logic                 wr_fire;
  logic                 last_word;
  logic                 addr_ok;

  // Loader handshake: a word transfers on a cycle where i_wr_vld and o_wr_rdy
  // are both high; o_wr_rdy is high exactly while in LOAD and never depends on
  // i_wr_vld, so the loader may hold or drop valid freely.
  assign wr_fire       = (state == LOAD) && i_wr_vld && o_wr_rdy;
  assign last_word     = wr_fire && (wr_addr == words_q - (AW+1)'(1)) && (bank == LAST_BANK);
  assign addr_ok       = ({1'b0, i_fb_addr} < words_q);
  assign words_clamped = (i_load_words > DEPTH_W) ? DEPTH_W : i_load_words;

  // Bank storage has no reset; writes only happen in LOAD, reads only in READY.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[bank][wr_addr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      words_q           <= '0;
      wr_addr           <= '0;
      bank              <= '0;
      o_wr_rdy          <= 1'b0;
      o_load_done       <= 1'b0;
      o_fb_req_possible <= 1'b0;
      o_fb_addr_err     <= 1'b0;
      for (int b = 0; b < Tout; b++) rd_data[b] <= '0;
    end else begin
      o_load_done   <= 1'b0;
      o_fb_addr_err <= 1'b0;
      // Reads are evaluated against the current state, so a read issued with
      // i_release is still served.
      if (i_fb_req) begin
        if (state == READY && addr_ok) begin
          for (int b = 0; b < Tout; b++) rd_data[b] <= mem[b][i_fb_addr];
        end else begin
          o_fb_addr_err <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (i_load_start && (i_load_words != '0)) begin
            state    <= LOAD;
            words_q  <= words_clamped;
            wr_addr  <= '0;
            bank     <= '0;
            o_wr_rdy <= 1'b1;
          end
        end
        LOAD: begin
          if (last_word) begin
            state             <= READY;
            o_wr_rdy          <= 1'b0;
            o_load_done       <= 1'b1;
            o_fb_req_possible <= 1'b1;
          end else if (wr_fire) begin
            if (bank == LAST_BANK) begin
              bank    <= '0;
              wr_addr <= wr_addr + (AW+1)'(1);
            end else begin
              bank <= bank + BW'(1);
            end
          end
        end
        READY: begin
          if (i_release) begin
            state             <= IDLE;
            o_fb_req_possible <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_fb_data0 = rd_data[0];
  assign o_fb_data1 = rd_data[1];
  assign o_fb_data2 = rd_data[2];
  assign o_fb_data3 = rd_data[3];
  assign fsm_state  = state;

endmodule

// File: tb/tb_filter_buffer.sv
// Testbench for filter_buffer: scenario tasks with inline checks and a read
// scoreboard holding the expected 4-bank read word.
module tb_filter_buffer;
  localparam int DW   = 72;
  localparam int AW   = 8;
  localparam int TOUT = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_words;
  logic          wr_vld;
  logic [DW-1:0] wr_data;
  logic          wr_rdy;
  logic          load_done;
  logic          rel;
  logic          req_possible;
  logic          fb_req;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] data0, data1, data2, data3;
  logic          addr_err;
  logic [1:0]    fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [4*DW-1:0] exp_q[$];
  logic [4*DW-1:0] last_exp;
  logic [DW-1:0]   tile[$];
  logic [4*DW-1:0] rd_all;

  assign rd_all = {data3, data2, data1, data0};

  filter_buffer #(.FILTER_DW(DW), .FILTER_BUFFER_AW(AW), .Tout(TOUT)) dut (
    .clk(clk), .rst(rst),
    .i_load_start(load_start), .i_load_words(load_words),
    .i_wr_vld(wr_vld), .i_wr_data(wr_data), .o_wr_rdy(wr_rdy),
    .o_load_done(load_done), .i_release(rel),
    .o_fb_req_possible(req_possible), .i_fb_req(fb_req), .i_fb_addr(fb_addr),
    .o_fb_data0(data0), .o_fb_data1(data1), .o_fb_data2(data2), .o_fb_data3(data3),
    .o_fb_addr_err(addr_err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [4*DW-1:0] got, input logic [4*DW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic make_tile(input int n);
    tile.delete();
    for (int i = 0; i < n; i++)
      tile.push_back({8'($urandom_range(255)), 32'($urandom), 32'($urandom)});
  endtask

  function automatic logic [4*DW-1:0] expected(input int a);
    return {tile[4*a+3], tile[4*a+2], tile[4*a+1], tile[4*a]};
  endfunction

  task automatic load_tile(input int words, input bit gaps);
    load_start = 1'b1;
    load_words = (AW+1)'(words);
    tick();
    load_start = 1'b0;
    chk("load_rdy", {287'd0, wr_rdy}, 1);
    chk("load_state", {286'd0, fsm_state}, {286'd0, S_LOAD});
    for (int i = 0; i < tile.size(); i++) begin
      if (gaps) begin
        wr_vld = 1'b0;
        tick();
        chk("gap_rdy", {287'd0, wr_rdy}, 1);
        chk("gap_done", {287'd0, load_done}, 0);
      end
      wr_vld  = 1'b1;
      wr_data = tile[i];
      tick();
      if (i < tile.size() - 1) chk("early_done", {287'd0, load_done}, 0);
    end
    wr_vld = 1'b0;
    chk("done_pulse", {287'd0, load_done}, 1);
    chk("rdy_after_load", {287'd0, wr_rdy}, 0);
    chk("req_possible", {287'd0, req_possible}, 1);
    tick();
    chk("done_one_cycle", {287'd0, load_done}, 0);
  endtask

  // Consecutive reads; optionally release on the same cycle as the last read.
  task automatic read_seq(input int addrs[], input bit rel_last);
    logic [4*DW-1:0] want;
    for (int i = 0; i < addrs.size(); i++) begin
      fb_req  = 1'b1;
      fb_addr = AW'(addrs[i]);
      rel     = rel_last && (i == addrs.size() - 1);
      exp_q.push_back(expected(addrs[i]));
      tick();
      want = exp_q.pop_front();
      chk($sformatf("read_addr%0d", addrs[i]), rd_all, want);
      chk("read_no_err", {287'd0, addr_err}, 0);
      last_exp = want;
    end
    fb_req = 1'b0;
    rel    = 1'b0;
  endtask

  task automatic bad_read(input int a, input string name);
    fb_req  = 1'b1;
    fb_addr = AW'(a);
    tick();
    fb_req = 1'b0;
    chk({name, "_err"}, {287'd0, addr_err}, 1);
    chk({name, "_hold"}, rd_all, last_exp);
    tick();
    chk({name, "_err_pulse"}, {287'd0, addr_err}, 0);
  endtask

  task automatic do_release();
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("release_possible", {287'd0, req_possible}, 0);
    chk("release_state", {286'd0, fsm_state}, {286'd0, S_IDLE});
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_state"}, {286'd0, fsm_state}, {286'd0, S_IDLE});
    chk({name, "_ctl"}, {284'd0, wr_rdy, load_done, req_possible, addr_err}, 0);
    chk({name, "_data"}, rd_all, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; load_words = '0; wr_vld = 1'b0; wr_data = '0;
    rel = 1'b0; fb_req = 1'b0; fb_addr = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    last_exp = '0;
  endtask

  task automatic test_load_basic();
    make_tile(8);
    load_tile(2, 1'b0);
    read_seq('{1, 0}, 1'b0);
    tick();
    chk("data_hold", rd_all, last_exp);
    do_release();
  endtask

  task automatic test_load_gaps();
    make_tile(8);
    load_tile(2, 1'b1);
    read_seq('{0, 1}, 1'b0);
  endtask

  task automatic test_addr_err();
    do_release();
    make_tile(8);
    load_start = 1'b1;
    load_words = (AW+1)'(2);
    tick();
    load_start = 1'b0;
    bad_read(0, "req_in_load");
    for (int i = 0; i < 8; i++) begin
      wr_vld  = 1'b1;
      wr_data = tile[i];
      tick();
    end
    wr_vld = 1'b0;
    chk("err_load_done", {287'd0, load_done}, 1);
    bad_read(2, "addr_oob");
    bad_read(255, "addr_max");
  endtask

  task automatic test_back_to_back();
    read_seq('{0, 1, 0}, 1'b0);
    read_seq('{1}, 1'b1);
    chk("rel_read_possible", {287'd0, req_possible}, 0);
    chk("rel_read_state", {286'd0, fsm_state}, {286'd0, S_IDLE});
  endtask

  task automatic test_reset_midload();
    make_tile(8);
    load_start = 1'b1;
    load_words = (AW+1)'(2);
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_vld  = 1'b1;
      wr_data = tile[i];
      tick();
    end
    wr_vld = 1'b0;
    rst    = 1'b1;
    tick();
    check_reset_outputs("midload_reset");
    rst      = 1'b0;
    last_exp = '0;
    make_tile(4);
    load_tile(1, 1'b0);
    read_seq('{0}, 1'b0);
    bad_read(1, "words1_oob");
  endtask

  task automatic test_ignored_start();
    load_start = 1'b1;
    load_words = (AW+1)'(2);
    tick();
    load_start = 1'b0;
    chk("start_in_ready_state", {286'd0, fsm_state}, {286'd0, S_READY});
    chk("start_in_ready_rdy", {287'd0, wr_rdy}, 0);
    read_seq('{0}, 1'b0);
    load_start = 1'b1;
    rel        = 1'b1;
    tick();
    load_start = 1'b0;
    rel        = 1'b0;
    chk("rel_wins_state", {286'd0, fsm_state}, {286'd0, S_IDLE});
    chk("rel_wins_rdy", {287'd0, wr_rdy}, 0);
    load_start = 1'b1;
    load_words = '0;
    tick();
    load_start = 1'b0;
    chk("zero_words_state", {286'd0, fsm_state}, {286'd0, S_IDLE});
    chk("zero_words_rdy", {287'd0, wr_rdy}, 0);
    tick();
    chk("zero_words_rdy_later", {287'd0, wr_rdy}, 0);
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_load_gaps();
    test_addr_err();
    test_back_to_back();
    test_reset_midload();
    test_ignored_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
